// File: rtl/ssp_rx_path_if.sv
// APB read-side bundle for the SSP receive path.
interface ssp_rx_path_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  PSEL;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (output PSEL, PWRITE, input PRDATA);
  modport slave  (input PSEL, PWRITE, output PRDATA);
endinterface

// File: rtl/ssp_rx_path.sv
// SSP receive path: oversampled serial input, MSB-first deserializer and a
// small show-ahead RX FIFO drained by APB reads.
module ssp_rx_path #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  ssp_rx_path_if.slave          apb,
  input  logic                  SSPCLKIN,
  input  logic                  SSPFSSIN,
  input  logic                  SSPRXD,
  output logic                  SSPRXINTR,
  output logic                  SSPRXOVR,
  output logic                  rx_not_empty,
  output logic [ADDR_WIDTH:0]   rx_level
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  logic [2:0]            clk_sync;
  logic [1:0]            fss_sync;
  logic [1:0]            rxd_sync;
  logic                  fall;
  logic                  fss;
  logic                  rxd;

  state_t                state;
  logic [CNT_W-1:0]      bitcnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] push_word;
  logic                  push;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  ovr;
  logic                  pop;
  logic                  wr_en;

  // Two flops of synchronization; the third clock flop only feeds edge detect.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      clk_sync <= '0;
      fss_sync <= '0;
      rxd_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[1:0], SSPCLKIN};
      fss_sync <= {fss_sync[0], SSPFSSIN};
      rxd_sync <= {rxd_sync[0], SSPRXD};
    end
  end

  assign fall      = clk_sync[2] & ~clk_sync[1];
  assign fss       = fss_sync[1];
  assign rxd       = rxd_sync[1];
  assign push_word = {shreg[DATA_WIDTH-2:0], rxd};
  assign push      = fall && (state == ST_SHIFT) && (bitcnt == LAST_BIT);

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state  <= ST_IDLE;
      bitcnt <= '0;
      shreg  <= '0;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (fss) begin
            state  <= ST_SHIFT;
            bitcnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (bitcnt == LAST_BIT) begin
            // FSS on the LSB edge starts the next frame without an idle gap.
            shreg  <= push_word;
            bitcnt <= '0;
            if (!fss) state <= ST_IDLE;
          end else if (fss) begin
            bitcnt <= '0;
          end else begin
            shreg  <= push_word;
            bitcnt <= bitcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pop   = apb.PSEL & ~apb.PWRITE & (count != '0);
  assign wr_en = push & ((count != FULL_CNT) | pop);

  always_ff @(posedge PCLK) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !wr_en) ovr <= 1'b1;
    end
  end

  assign apb.PRDATA   = (count != '0) ? mem[rd_ptr] : '0;
  assign SSPRXINTR    = (count == FULL_CNT);
  assign SSPRXOVR     = ovr;
  assign rx_not_empty = (count != '0);
  assign rx_level     = count;
endmodule

// File: tb/tb_ssp_rx_path.sv
// Directed bench for ssp_rx_path: serial frames at 8 PCLK per SSPCLK, APB pops.
module tb_ssp_rx_path;
  logic       PCLK = 1'b0;
  logic       CLEAR_B = 1'b0;
  logic       SSPCLKIN = 1'b0;
  logic       SSPFSSIN = 1'b0;
  logic       SSPRXD = 1'b0;
  logic       SSPRXINTR;
  logic       SSPRXOVR;
  logic       rx_not_empty;
  logic [2:0] rx_level;

  int n_vec = 0;
  int n_err = 0;

  ssp_rx_path_if #(.DATA_WIDTH(8)) apb ();

  ssp_rx_path #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .PCLK        (PCLK),
    .CLEAR_B     (CLEAR_B),
    .apb         (apb),
    .SSPCLKIN    (SSPCLKIN),
    .SSPFSSIN    (SSPFSSIN),
    .SSPRXD      (SSPRXD),
    .SSPRXINTR   (SSPRXINTR),
    .SSPRXOVR    (SSPRXOVR),
    .rx_not_empty(rx_not_empty),
    .rx_level    (rx_level)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One SSPCLK period: 4 PCLK high, 4 PCLK low. With pop_at_fall the APB pop
  // lands on the PCLK cycle in which the DUT pushes the word of this fall.
  task automatic sclk_cycle(input logic fss, input logic rxd, input bit pop_at_fall);
    SSPFSSIN = fss;
    SSPRXD   = rxd;
    SSPCLKIN = 1'b1;
    repeat (4) @(negedge PCLK);
    SSPCLKIN = 1'b0;
    if (pop_at_fall) begin
      repeat (2) @(negedge PCLK);
      apb.PSEL   = 1'b1;
      apb.PWRITE = 1'b0;
      @(negedge PCLK);
      apb.PSEL = 1'b0;
      @(negedge PCLK);
    end else begin
      repeat (4) @(negedge PCLK);
    end
  endtask

  task automatic send_word(input logic [7:0] word, input logic fss_on_lsb, input bit pop_on_lsb);
    for (int i = 7; i >= 0; i--)
      sclk_cycle((i == 0) ? fss_on_lsb : 1'b0, word[i], (i == 0) ? pop_on_lsb : 1'b0);
    $display("sent 0x%02h", word);
  endtask

  task automatic frame(input logic [7:0] word, input bit pop_on_lsb);
    sclk_cycle(1'b1, 1'b0, 1'b0);
    send_word(word, 1'b0, pop_on_lsb);
    SSPFSSIN = 1'b0;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check_vec(tag, apb.PRDATA, exp);
    apb.PSEL   = 1'b1;
    apb.PWRITE = 1'b0;
    @(negedge PCLK);
    apb.PSEL = 1'b0;
    $display("pop expected 0x%02h", exp);
  endtask

  task automatic wait_level(input logic [2:0] lvl);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (rx_level == lvl) hit = 1'b1;
      else @(negedge PCLK);
    end
    if (!hit) check_vec("wait_level_timeout", rx_level, lvl);
  endtask

  task automatic reset_pulse();
    CLEAR_B = 1'b0;
    repeat (2) @(negedge PCLK);
    CLEAR_B = 1'b1;
    @(negedge PCLK);
  endtask

  initial begin
    apb.PSEL   = 1'b0;
    apb.PWRITE = 1'b0;
    repeat (3) @(negedge PCLK);
    CLEAR_B = 1'b1;
    repeat (3) @(negedge PCLK);

    // Reset / idle
    check_vec("rst_level", rx_level, 0);
    check_vec("rst_nempty", rx_not_empty, 0);
    check_vec("rst_intr", SSPRXINTR, 0);
    check_vec("rst_ovr", SSPRXOVR, 0);
    check_vec("rst_prdata", apb.PRDATA, 8'h00);
    pop_chk("empty_pop_prdata", 8'h00);
    check_vec("empty_pop_level", rx_level, 0);

    // Single frame, a write that must be ignored, then a pop
    frame(8'hA5, 1'b0);
    check_vec("single_level", rx_level, 1);
    check_vec("single_nempty", rx_not_empty, 1);
    check_vec("single_intr", SSPRXINTR, 0);
    apb.PSEL = 1'b1; apb.PWRITE = 1'b1;
    @(negedge PCLK);
    apb.PSEL = 1'b0; apb.PWRITE = 1'b0;
    check_vec("write_level", rx_level, 1);
    pop_chk("single_prdata", 8'hA5);
    check_vec("single_pop_level", rx_level, 0);
    check_vec("single_pop_prdata", apb.PRDATA, 8'h00);

    // Back-to-back frames with pointer wrap, popping after every second push
    fork
      begin
        sclk_cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++)
          send_word(8'(k), (k != 6), 1'b0);
        SSPFSSIN = 1'b0;
      end
      begin
        for (int p = 0; p < 3; p++) begin
          wait_level(3'd2);
          pop_chk("b2b_word", 8'(2 * p + 1));
          pop_chk("b2b_word", 8'(2 * p + 2));
        end
      end
    join
    repeat (2) @(negedge PCLK);
    check_vec("b2b_level", rx_level, 0);
    check_vec("b2b_ovr", SSPRXOVR, 0);

    // Fill to full, then overrun
    frame(8'h11, 1'b0);
    frame(8'h22, 1'b0);
    frame(8'h33, 1'b0);
    frame(8'h44, 1'b0);
    check_vec("full_intr", SSPRXINTR, 1);
    check_vec("full_level", rx_level, 4);
    check_vec("full_ovr", SSPRXOVR, 0);
    frame(8'h55, 1'b0);
    check_vec("ovr_set", SSPRXOVR, 1);
    check_vec("ovr_level", rx_level, 4);
    pop_chk("ovr_rd", 8'h11);
    pop_chk("ovr_rd", 8'h22);
    pop_chk("ovr_rd", 8'h33);
    pop_chk("ovr_rd", 8'h44);
    check_vec("ovr_drained", rx_level, 0);
    check_vec("ovr_intr_clr", SSPRXINTR, 0);
    check_vec("ovr_sticky", SSPRXOVR, 1);

    // Simultaneous push and pop while full
    reset_pulse();
    check_vec("ovr_cleared", SSPRXOVR, 0);
    frame(8'h12, 1'b0);
    frame(8'h34, 1'b0);
    frame(8'h56, 1'b0);
    frame(8'h78, 1'b0);
    check_vec("pp_full", rx_level, 4);
    check_vec("pp_head", apb.PRDATA, 8'h12);
    frame(8'h66, 1'b1);
    check_vec("pp_level", rx_level, 4);
    check_vec("pp_ovr", SSPRXOVR, 0);
    pop_chk("pp_rd", 8'h34);
    pop_chk("pp_rd", 8'h56);
    pop_chk("pp_rd", 8'h78);
    pop_chk("pp_rd_last", 8'h66);
    check_vec("pp_empty", rx_level, 0);

    // FSS re-asserted mid-word restarts the frame
    sclk_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) sclk_cycle(1'b0, 1'b1, 1'b0);
    sclk_cycle(1'b1, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    SSPFSSIN = 1'b0;
    repeat (2) @(negedge PCLK);
    check_vec("abort_level", rx_level, 1);
    check_vec("abort_prdata", apb.PRDATA, 8'h3C);

    // Reset in the middle of a frame, 0x3C still buffered
    sclk_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) sclk_cycle(1'b0, 1'b1, 1'b0);
    reset_pulse();
    check_vec("mid_rst_level", rx_level, 0);
    check_vec("mid_rst_nempty", rx_not_empty, 0);
    check_vec("mid_rst_prdata", apb.PRDATA, 8'h00);
    frame(8'hC3, 1'b0);
    check_vec("post_rst_level", rx_level, 1);
    pop_chk("post_rst_prdata", 8'hC3);
    check_vec("post_rst_empty", rx_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
